// File: rtl/ascii_binary_assembler.sv
// rtl/ascii_binary_assembler.sv - ASCII '0'/'1' stream to binary word assembler with valid/ready ports
// Optional per-keystroke echo trace enabled by defining ASM_ECHO_EN.
module ascii_binary_assembler #(
  parameter int WIDTH = 8,
  localparam int LENW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic [LENW-1:0]  out_len,
  output logic             out_ovf,
`ifdef ASM_ECHO_EN
  output logic             echo_valid,
  output logic             echo_bit,
`endif
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2,
    ENDED   = 2'd3
  } state_t;

  localparam logic [LENW-1:0] CNT_MAX = LENW'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [LENW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             end_pend_q, end_pend_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_word_q, out_word_d;
  logic [LENW-1:0]  out_len_q, out_len_d;
  logic             out_ovf_q, out_ovf_d;
  logic             done_q, done_d;

  logic accept;
  logic is_digit;
  logic is_lf;
  logic is_cr;

  // Acceptance is gated by rst so the reset cycle never takes a character.
  assign in_ready = !rst && ((state_q == IDLE) || (state_q == COLLECT));
  assign accept   = in_valid && in_ready;
  assign is_digit = (in_data[7:1] == 7'b0011000);
  assign is_lf    = (in_data == 8'h0A);
  assign is_cr    = (in_data == 8'h0D);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    end_pend_d  = end_pend_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_len_d   = out_len_q;
    out_ovf_d   = out_ovf_q;
    done_d      = done_q;

    case (state_q)
      IDLE, COLLECT: begin
        if (accept) begin
          if (is_digit) begin
            acc_d = {acc_q[WIDTH-2:0], in_data[0]};
            if (cnt_q == CNT_MAX) begin
              ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q + LENW'(1);
            end
            state_d = COLLECT;
          end else if (is_lf) begin
            if (state_q == COLLECT) begin
              out_word_d  = acc_q;
              out_len_d   = cnt_q;
              out_ovf_d   = ovf_q;
              out_valid_d = 1'b1;
              state_d     = HOLD;
            end
          end else if (!is_cr) begin
            end_pend_d = 1'b1;
            if (state_q == COLLECT) begin
              out_word_d  = acc_q;
              out_len_d   = cnt_q;
              out_ovf_d   = ovf_q;
              out_valid_d = 1'b1;
              state_d     = HOLD;
            end else begin
              done_d  = 1'b1;
              state_d = ENDED;
            end
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
          if (end_pend_q) begin
            done_d  = 1'b1;
            state_d = ENDED;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = ENDED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      end_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_len_q   <= '0;
      out_ovf_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      end_pend_q  <= end_pend_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_len_q   <= out_len_d;
      out_ovf_q   <= out_ovf_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_len   = out_len_q;
  assign out_ovf   = out_ovf_q;
  assign done      = done_q;

`ifdef ASM_ECHO_EN
  logic echo_valid_q;
  logic echo_bit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      echo_valid_q <= 1'b0;
      echo_bit_q   <= 1'b0;
    end else begin
      echo_valid_q <= accept && is_digit;
      echo_bit_q   <= (accept && is_digit) ? in_data[0] : echo_bit_q;
    end
  end

  assign echo_valid = echo_valid_q;
  assign echo_bit   = echo_bit_q;
`endif

endmodule

// File: tb/tb_ascii_binary_assembler.sv
// tb/tb_ascii_binary_assembler.sv - scoreboard bench for ascii_binary_assembler
// Exercises echo ports when ASM_ECHO_EN is defined.
module tb_ascii_binary_assembler;

  localparam int WIDTH = 8;
  localparam int LENW  = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_word;
  logic [LENW-1:0]  out_len;
  logic             out_ovf;
  logic             done;
`ifdef ASM_ECHO_EN
  logic             echo_valid;
  logic             echo_bit;
  logic             echo_q[$];
`endif

  typedef struct packed {
    logic [WIDTH-1:0] word;
    logic [LENW-1:0]  len;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  ascii_binary_assembler #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_len   (out_len),
    .out_ovf   (out_ovf),
`ifdef ASM_ECHO_EN
    .echo_valid(echo_valid),
    .echo_bit  (echo_bit),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake is decided at the next rising edge, so sample on the falling edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(out_word), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_word", 32'(out_word), 32'(e.word));
        check("out_len",  32'(out_len),  32'(e.len));
        check("out_ovf",  32'(out_ovf),  32'(e.ovf));
      end
    end
  end

`ifdef ASM_ECHO_EN
  always @(negedge clk) begin
    if (!rst && echo_valid) echo_q.push_back(echo_bit);
  end
`endif

  task automatic send_char(input logic [7:0] c);
    int budget;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = c;
    budget   = 0;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] w, input logic [LENW-1:0] l, input logic o);
    exp_t e;
    e.word = w;
    e.len  = l;
    e.ovf  = o;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("word_delivered", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;

    // 1: reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_word",  32'(out_word),  32'd0);
    check("rst_out_len",   32'(out_len),   32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 2: "101\n"
`ifdef ASM_ECHO_EN
    echo_q.delete();
`endif
    push_exp(8'h05, 4'd3, 1'b0);
    send_str("101\n");
    wait_drain();
    @(negedge clk);
    check("t2_done",     32'(done),     32'd0);
    check("t2_in_ready", 32'(in_ready), 32'd1);
`ifdef ASM_ECHO_EN
    check("echo_count", 32'(echo_q.size()), 32'd3);
    if (echo_q.size() == 3) begin
      check("echo_bit0", 32'(echo_q[0]), 32'd1);
      check("echo_bit1", 32'(echo_q[1]), 32'd0);
      check("echo_bit2", 32'(echo_q[2]), 32'd1);
    end
`endif

    // 3: overflow keeps the last WIDTH digits
    push_exp(8'hC3, 4'd8, 1'b1);
    send_str("1111000011\n");
    wait_drain();

    // 4: empty lines produce nothing; an extra word would hit an empty scoreboard
    send_str("\n");
    send_str("\r\n");
    repeat (3) @(negedge clk);
    check("t4_no_word", 32'(out_valid), 32'd0);
    push_exp(8'h02, 4'd2, 1'b0);
    send_str("10\n");
    wait_drain();

    // 5: non-digit ends the session after emitting the partial word
    push_exp(8'h03, 4'd2, 1'b0);
    send_str("11x");
    wait_drain();
    @(negedge clk);
    check("t5_done",     32'(done),     32'd1);
    check("t5_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h31;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_ended_in_ready",  32'(in_ready),  32'd0);
      check("t5_ended_out_valid", 32'(out_valid), 32'd0);
      check("t5_ended_done",      32'(done),      32'd1);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // 6: stalled consumer, then reset drops the presented word
    out_ready = 1'b0;
    send_str("1\n");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_out_valid", 32'(out_valid), 32'd1);
      check("t6_out_word",  32'(out_word),  32'h01);
      check("t6_out_len",   32'(out_len),   32'd1);
      check("t6_in_ready",  32'(in_ready),  32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_out_word",  32'(out_word),  32'd0);
    check("t6_rst_done",      32'(done),      32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("t6_idle_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("t6_no_word", 32'(out_valid), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
